// File: rtl/karatsuba_mul_pipe.sv
// Three-stage pipelined unsigned NxN Karatsuba multiplier with per-transaction
// exact/approximate mode (low sub-product truncation) and a sideband tag.
module karatsuba_mul_pipe #(
    parameter int N           = 16,
    parameter int APPROX_BITS = 4,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    input  logic               in_approx,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     out_p,
    output logic               out_approx,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);
    localparam int K = N / 2;

    generate
        if ((N % 2) != 0 || N < 4 || APPROX_BITS < 0 || APPROX_BITS > N) begin : g_bad_param
            $error("karatsuba_mul_pipe: N must be even and >= 4, 0 <= APPROX_BITS <= N");
        end
    endgenerate

    // Shifting past the width yields zero, so APPROX_BITS == N clears all of L.
    localparam logic [2*K-1:0] LMASK = {(2*K){1'b1}} << APPROX_BITS;

    logic [3:1]        vld_pipe;
    logic              adv;

    logic [K-1:0]      s1_ah, s1_al, s1_bh, s1_bl;
    logic [K:0]        s1_sa, s1_sb;
    logic              s1_ap;
    logic [TAG_W-1:0]  s1_tag;

    logic [2*K-1:0]    s2_h, s2_l;
    logic [2*K+1:0]    s2_m;
    logic              s2_ap;
    logic [TAG_W-1:0]  s2_tag;

    logic [2*K-1:0]    l_full, l_trunc, h_full;
    logic [2*K+1:0]    m_full, mid;
    logic [2*N-1:0]    p_nxt, mid_ext;

    assign adv       = !vld_pipe[3] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[3];
    assign occupancy = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]} + {1'b0, vld_pipe[3]};

    assign h_full  = {{K{1'b0}}, s1_ah} * {{K{1'b0}}, s1_bh};
    assign l_full  = {{K{1'b0}}, s1_al} * {{K{1'b0}}, s1_bl};
    assign l_trunc = s1_ap ? (l_full & LMASK) : l_full;
    assign m_full  = {{(K+1){1'b0}}, s1_sa} * {{(K+1){1'b0}}, s1_sb};

    // MID absorbs the truncation error, so it stays non-negative.
    assign mid = s2_m - {2'b00, s2_h} - {2'b00, s2_l};

    always_comb begin
        mid_ext = '0;
        mid_ext[K +: 2*K+2] = mid;
        p_nxt = {s2_h, {N{1'b0}}} + mid_ext + {{(2*N-2*K){1'b0}}, s2_l};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1_ah      <= '0;
            s1_al      <= '0;
            s1_bh      <= '0;
            s1_bl      <= '0;
            s1_sa      <= '0;
            s1_sb      <= '0;
            s1_ap      <= 1'b0;
            s1_tag     <= '0;
            s2_h       <= '0;
            s2_l       <= '0;
            s2_m       <= '0;
            s2_ap      <= 1'b0;
            s2_tag     <= '0;
            out_p      <= '0;
            out_approx <= 1'b0;
            out_tag    <= '0;
        end else if (adv) begin
            // Bubbles travel with the data; nothing is collapsed.
            vld_pipe   <= {vld_pipe[2:1], in_valid};
            s1_ah      <= in_a[N-1:K];
            s1_al      <= in_a[K-1:0];
            s1_bh      <= in_b[N-1:K];
            s1_bl      <= in_b[K-1:0];
            s1_sa      <= {1'b0, in_a[N-1:K]} + {1'b0, in_a[K-1:0]};
            s1_sb      <= {1'b0, in_b[N-1:K]} + {1'b0, in_b[K-1:0]};
            s1_ap      <= in_approx;
            s1_tag     <= in_tag;
            s2_h       <= h_full;
            s2_l       <= l_trunc;
            s2_m       <= m_full;
            s2_ap      <= s1_ap;
            s2_tag     <= s1_tag;
            out_p      <= p_nxt;
            out_approx <= s2_ap;
            out_tag    <= s2_tag;
        end
    end
endmodule

// File: tb/tb_karatsuba_mul_pipe.sv
// Bench for karatsuba_mul_pipe: scoreboard of arithmetic products, directed
// corners, backpressure, mid-stream reset and an N=8 full-truncation build.
module tb_karatsuba_mul_pipe;
    localparam int N  = 16;
    localparam int K  = N / 2;
    localparam int AB = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid, in_ready, in_approx;
    logic [N-1:0]  in_a, in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid, out_ready, out_approx;
    logic [2*N-1:0] out_p;
    logic [TW-1:0] out_tag;
    logic [1:0]    occupancy;

    logic          b_in_valid, b_in_ready, b_in_approx;
    logic [7:0]    b_in_a, b_in_b;
    logic [TW-1:0] b_in_tag;
    logic          b_out_valid, b_out_ready, b_out_approx;
    logic [15:0]   b_out_p;
    logic [TW-1:0] b_out_tag;
    logic [1:0]    b_occupancy;

    always #5 clk = ~clk;

    karatsuba_mul_pipe #(.N(N), .APPROX_BITS(AB), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_approx(out_approx), .out_tag(out_tag), .occupancy(occupancy)
    );

    karatsuba_mul_pipe #(.N(8), .APPROX_BITS(8), .TAG_W(TW)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b),
        .in_approx(b_in_approx), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_p(b_out_p),
        .out_approx(b_out_approx), .out_tag(b_out_tag), .occupancy(b_occupancy)
    );

    typedef struct {
        logic [2*N-1:0] p;
        logic           ap;
        logic [TW-1:0]  tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nout = 0;
    int   max_occ = 0;
    bit   rnd_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // a*b plus the error introduced by clearing the low AB bits of AL*BL.
    function automatic logic [2*N-1:0] ref_p(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic ap);
        longint unsigned al, bl, e, full;
        al = 64'(a) % (64'd1 << K);
        bl = 64'(b) % (64'd1 << K);
        e  = ap ? (al * bl) % (64'd1 << AB) : 64'd0;
        full = 64'(a) * 64'(b) + (e << K) - e;
        return full[2*N-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
                else begin
                    chk("out_p", 64'(out_p), 64'(q[0].p));
                    chk("out_tag", 64'(out_tag), 64'(q[0].tag));
                    chk("out_approx", 64'(out_approx), 64'(q[0].ap));
                    if (out_ready) begin
                        void'(q.pop_front());
                        nout++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back('{ref_p(in_a, in_b, in_approx), in_approx, in_tag});
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the input transfer.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic ap,
                         input logic [TW-1:0] tg);
        int n = 0;
        in_a = a; in_b = b; in_approx = ap; in_tag = tg; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("in_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Counts negedges from just after an input transfer until out_valid.
    task automatic wait_lat(input string tg);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk(tg, 64'(lat), 64'd3);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        in_valid = 0; in_a = 0; in_b = 0; in_approx = 0; in_tag = 0; out_ready = 0;
        b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_approx = 0; b_in_tag = 0; b_out_ready = 1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_approx", 64'(out_approx), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        #3 rst_n = 1'b1;
        realign();
        out_ready = 1'b1;

        drive(16'hFFFF, 16'hFFFF, 1'b0, 4'h3); idle();
        wait_lat("lat_exact");
        chk("ffff_exact_p", 64'(out_p), 64'hFFFE0001);
        chk("ffff_exact_tag", 64'(out_tag), 64'h3);
        realign();

        drive(16'hFFFF, 16'hFFFF, 1'b1, 4'h5); idle();
        wait_lat("lat_approx");
        chk("ffff_approx_p", 64'(out_p), 64'hFFFE0100);
        chk("ffff_approx_mode", 64'(out_approx), 64'd1);
        realign();
        drive(16'h1234, 16'h5678, 1'b1, 4'h6); idle();
        wait_lat("lat_1234");
        chk("1234_approx_p", 64'(out_p), 64'h06260060);
        realign();

        max_occ = 0;
        n0 = nout;
        for (int i = 0; i < 8; i++)
            drive(N'($urandom), N'($urandom), i[0], TW'(i));
        idle();
        repeat (6) realign();
        chk("stream_max_occ", 64'(max_occ), 64'd3);
        chk("stream_count", 64'(nout - n0), 64'd8);

        n0 = nout;
        for (int i = 0; i < 4; i++)
            drive(N'($urandom), N'($urandom), $urandom_range(0, 1) == 1, TW'(i + 8));
        idle();
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_occupancy", 64'(occupancy), 64'd3);
        end
        realign();
        out_ready = 1'b1;
        repeat (6) realign();
        chk("bp_count", 64'(nout - n0), 64'd4);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        drive(16'hABCD, 16'h1357, 1'b0, 4'hA);
        drive(16'h2468, 16'hFEDC, 1'b1, 4'hB);
        idle();
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_p", 64'(out_p), 64'd0);
        q.delete();
        #2 rst_n = 1'b1;
        realign();
        drive(16'h0001, 16'h0001, 1'b0, 4'hC); idle();
        wait_lat("lat_post_rst");
        chk("post_rst_p", 64'(out_p), 64'd1);
        realign();

        drive(16'h0000, 16'hFFFF, 1'b0, 4'h1);
        drive(16'h0000, 16'hFFFF, 1'b1, 4'h2);
        drive(16'h00FF, 16'hFF00, 1'b0, 4'h3);
        drive(16'h00FF, 16'hFF00, 1'b1, 4'h4);
        drive(16'h00FF, 16'h00FF, 1'b1, 4'h5);
        idle();
        repeat (6) realign();
        chk("corner_queue_empty", 64'(q.size()), 64'd0);

        rnd_done = 1'b0;
        n0 = nout;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    drive(N'($urandom), N'($urandom), $urandom_range(0, 1) == 1, TW'($urandom));
                    if ($urandom_range(0, 2) == 0) begin
                        idle();
                        realign();
                    end
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    realign();
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        out_ready = 1'b1;
        repeat (8) realign();
        chk("rand_count", 64'(nout - n0), 64'd60);
        chk("rand_queue_empty", 64'(q.size()), 64'd0);

        // N=8, APPROX_BITS=8: L' is zero, so out_p = (a*b + (e<<4) - e) mod 2^16.
        for (int i = 0; i < 2; i++) begin
            int lat;
            logic [15:0] exp8;
            exp8 = (i == 0) ? 16'hFE01 : 16'h0B30;
            b_in_a = 8'hFF; b_in_b = 8'hFF; b_in_approx = (i == 1); b_in_tag = TW'(i + 2);
            b_in_valid = 1'b1;
            realign();
            b_in_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!b_out_valid && lat < 20);
            chk("n8_lat", 64'(lat), 64'd3);
            chk("n8_p", 64'(b_out_p), 64'(exp8));
            chk("n8_approx", 64'(b_out_approx), 64'(i));
            chk("n8_tag", 64'(b_out_tag), 64'(i + 2));
            realign();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
